// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready target with fixed access latency.
// One outstanding request; word/byte loads and stores with error flag.
module dm_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          we_q;
  logic          byte_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic          oor;
  logic          misal;
  logic          err_c;
  logic          fire;
  logic [4:0]    sh;
  logic [31:0]   cur;
  logic [31:0]   merged;
  logic [7:0]    lane_b;
  logic [31:0]   rdata_c;

  always_comb begin
    idx    = addr_q[AW+1:2];
    // Any address bit beyond the word index pushes it out of range.
    oor    = 32'(addr_q[31:2]) >= 32'(DEPTH);
    misal  = !byte_q && (addr_q[1:0] != 2'b00);
    err_c  = oor || misal;
    fire   = (state == BUSY) && (cnt == 4'd0);
    sh     = {addr_q[1:0], 3'b000};
    cur    = mem[idx];
    lane_b = 8'(cur >> sh);
    merged = (cur & ~(32'h0000_00ff << sh))
           | (32'(wdata_q[7:0]) << sh);
    rdata_c = '0;
    if (!err_c && !we_q) begin
      if (byte_q) rdata_c = {{24{lane_b[7]}}, lane_b};
      else        rdata_c = cur;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            byte_q  <= req_byte;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 4'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_rdata <= rdata_c;
            resp_err   <= err_c;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is touched only on the cycle the access completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (fire && we_q && !err_c) begin
      mem[idx] <= byte_q ? merged : wdata_q;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: byte-addressed reference model, three
// instances at latencies 2, 1 and 7, directed and random traffic.
module tb_dm_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we [3];
  logic        req_byte [3];
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err [3];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dm_responder #(
      .DEPTH(DEPTH),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 7))
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we(req_we[g]),
      .req_byte(req_byte[g]),
      .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err(resp_err[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %h, want %h", nm, k, act, exp);
  endtask

  // Reference model: byte-addressed memory, one pending response each.
  logic [7:0]  mb [3][DEPTH*4];
  bit          pend [3];
  int          acc [3];
  logic [31:0] erd [3];
  bit          eerr [3];

  task automatic model_access(input int k);
    int unsigned w;
    int ln;
    int base;
    w  = req_addr[k] >> 2;
    ln = int'(req_addr[k] & 32'd3);
    eerr[k] = (!req_byte[k] && ln != 0) || (w >= DEPTH);
    erd[k]  = '0;
    if (!eerr[k]) begin
      base = int'(w) * 4;
      if (req_byte[k]) begin
        if (req_we[k]) mb[k][base+ln] = req_wdata[k][7:0];
        else erd[k] = 32'($signed(mb[k][base+ln]));
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (req_we[k]) mb[k][base+i] = req_wdata[k][8*i +: 8];
          else erd[k][8*i +: 8] = mb[k][base+i];
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        pend[k] = 0;
        for (int i = 0; i < DEPTH*4; i++) mb[k][i] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (pend[k]) begin
          if (cyc + 1 > acc[k] + lat_of(k) && resp_ready[k]) pend[k] = 0;
        end else if (req_valid[k]) begin
          model_access(k);
          pend[k] = 1;
          acc[k]  = cyc + 1;
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit ev;
      ev = pend[k] && (cyc >= acc[k] + lat_of(k));
      chk("req_ready", k, 32'(req_ready[k]), 32'(!pend[k]));
      chk("resp_valid", k, 32'(resp_valid[k]), 32'(ev));
      chk("resp_rdata", k, resp_rdata[k], ev ? erd[k] : 32'd0);
      chk("resp_err", k, 32'(resp_err[k]), ev ? 32'(eerr[k]) : 32'd0);
    end
  end

  task automatic xact(input int k, input bit we, input bit by,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int hold,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int ac);
    int n;
    req_we[k]    = we;
    req_byte[k]  = by;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_valid[k] = 1'b1;
    resp_ready[k] = (hold == 0);
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", k, 32'd1, 32'd0);
    @(negedge clk);
    ac = cyc;
    req_valid[k] = 1'b0;
    n = 0;
    while (!resp_valid[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("resp_timeout", k, 32'd1, 32'd0);
    lat = cyc - ac;
    rd  = resp_rdata[k];
    er  = resp_err[k];
    if (hold > 0) begin
      // A competing store held during the stall must be ignored.
      req_we[k]    = 1'b1;
      req_byte[k]  = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'hBAD0_BAD0;
      req_valid[k] = 1'b1;
      repeat (hold) @(negedge clk);
      resp_ready[k] = 1'b1;
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  task automatic rnd(input int k, input int cnt);
    logic [31:0] rd;
    logic er;
    int lat;
    int ac;
    logic [31:0] a;
    for (int i = 0; i < cnt; i++) begin
      case ($urandom % 8)
        0: a = 32'h1000 + ($urandom % 16);
        1: a = $urandom;
        default: a = (($urandom % 16) << 2) | ($urandom % 4);
      endcase
      xact(k, 1'($urandom % 2), 1'($urandom % 2), a, $urandom,
           int'($urandom % 3), rd, er, lat, ac);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    int a1;
    int a2;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 0; req_we[k] = 0; req_byte[k] = 0;
      req_addr[k] = '0; req_wdata[k] = '0; resp_ready[k] = 1;
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("rst_valid", 0, 32'(resp_valid[0]), 32'd0);
    chk("rst_rdata", 0, resp_rdata[0], 32'd0);

    xact(0, 1, 0, 32'h10, 32'h1234_5678, 0, rd, er, lat, a1);
    chk("sw_lat", 0, 32'(lat), 32'd2);
    chk("sw_rd", 0, rd, 32'd0);
    chk("sw_err", 0, 32'(er), 32'd0);
    xact(0, 0, 0, 32'h10, 32'h0, 0, rd, er, lat, a1);
    chk("lw_10", 0, rd, 32'h1234_5678);

    xact(0, 1, 0, 32'h20, 32'h0, 0, rd, er, lat, a1);
    xact(0, 1, 1, 32'h23, 32'hF0, 0, rd, er, lat, a1);
    xact(0, 0, 0, 32'h20, 32'h0, 0, rd, er, lat, a1);
    chk("lw_20", 0, rd, 32'hF000_0000);
    xact(0, 0, 1, 32'h23, 32'h0, 0, rd, er, lat, a1);
    chk("lb_23", 0, rd, 32'hFFFF_FFF0);
    xact(0, 0, 1, 32'h20, 32'h0, 0, rd, er, lat, a1);
    chk("lb_20", 0, rd, 32'h0);

    xact(0, 0, 0, 32'h22, 32'h0, 0, rd, er, lat, a1);
    chk("lw_mis_err", 0, 32'(er), 32'd1);
    chk("lw_mis_rd", 0, rd, 32'd0);
    xact(0, 1, 0, 32'h0, 32'hCAFE_0001, 0, rd, er, lat, a1);
    xact(0, 1, 0, 32'h1002, 32'h1111_1111, 0, rd, er, lat, a1);
    chk("sw_1002_err", 0, 32'(er), 32'd1);
    xact(0, 1, 0, 32'h1000, 32'h2222_2222, 0, rd, er, lat, a1);
    chk("sw_1000_err", 0, 32'(er), 32'd1);
    xact(0, 0, 0, 32'h0, 32'h0, 0, rd, er, lat, a1);
    chk("lw_0_kept", 0, rd, 32'hCAFE_0001);

    xact(0, 0, 0, 32'h10, 32'h0, 5, rd, er, lat, a1);
    chk("bp_rd", 0, rd, 32'h1234_5678);
    xact(0, 0, 0, 32'h0, 32'h0, 0, rd, er, lat, a2);
    chk("bp_no_write", 0, rd, 32'hCAFE_0001);
    chk("bp_spacing", 0, 32'(a2 - a1), 32'd9);

    xact(0, 0, 0, 32'h10, 32'h0, 0, rd, er, lat, a1);
    xact(0, 0, 0, 32'h20, 32'h0, 0, rd, er, lat, a2);
    chk("b2b_spacing", 0, 32'(a2 - a1), 32'd4);
    chk("b2b_rd", 0, rd, 32'hF000_0000);

    req_we[0] = 1; req_byte[0] = 0; req_addr[0] = 32'h40;
    req_wdata[0] = 32'hDEAD_BEEF; req_valid[0] = 1; resp_ready[0] = 1;
    @(negedge clk);
    req_valid[0] = 0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("async_rst_valid", 0, 32'(resp_valid[0]), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    xact(0, 0, 0, 32'h40, 32'h0, 0, rd, er, lat, a1);
    chk("lw_40_cleared", 0, rd, 32'd0);

    rnd(0, 150);

    for (int k = 1; k < 3; k++) begin
      xact(k, 1, 0, 32'h8, 32'h5A5A_00C3, 0, rd, er, lat, a1);
      chk("sweep_lat", k, 32'(lat), 32'(lat_of(k)));
      xact(k, 0, 0, 32'h8, 32'h0, 0, rd, er, lat, a1);
      xact(k, 0, 1, 32'h8, 32'h0, 0, rd, er, lat, a2);
      chk("sweep_spacing", k, 32'(a2 - a1), 32'(lat_of(k) + 2));
      chk("sweep_lb", k, rd, 32'hFFFF_FFC3);
      rnd(k, 25);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
